shift_unit: RTL and testbench

Multicycle shifter for the MIPS datapath. It sits directly downstream of the shift-amount multiplexer and consumes that mux's 5-bit output as its shift count. It latches an operand and a shift operation on `start`, shifts one bit position per clock, and signals completion with a one-cycle `done` pulse. The main control FSM waits on `done` before writing `data_out` back through the register-file write mux.

---
 rtl/shift_unit.sv | 110 +++++++++++
 tb/tb_shift_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multicycle 32-bit shifter, one bit position per clock
// Optional rotates (ROL/ROR) are built only when SHIFT_ROTATE_EN is defined.
module shift_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  state_t      state;
  state_t      state_n;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [4:0]  eff_cnt;
  logic        load;
  logic [31:0] step_d;

  // Pass ops (and rotates when compiled out) finish with no shift steps.
  always_comb begin
    eff_cnt = 5'd0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: eff_cnt = shamt;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         eff_cnt = shamt;
`else
      OP_ROL, OP_ROR:         eff_cnt = 5'd0;
`endif
      default:                eff_cnt = 5'd0;
    endcase
  end

  always_comb begin
    step_d = data_out;
    case (op_q)
      OP_SLL:  step_d = {data_out[30:0], 1'b0};
      OP_SRL:  step_d = {1'b0, data_out[31:1]};
      OP_SRA:  step_d = {data_out[31], data_out[31:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROL:  step_d = {data_out[30:0], data_out[31]};
      OP_ROR:  step_d = {data_out[0], data_out[31:1]};
`endif
      default: step_d = data_out;
    endcase
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (eff_cnt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 5'd1) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (eff_cnt == 5'd0) ? DONE : SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      data_out <= 32'd0;
      cnt      <= 5'd0;
      op_q     <= 3'd0;
    end else begin
      state <= state_n;
      if (load) begin
        data_out <= data_in;
        op_q     <= op;
        cnt      <= eff_cnt;
      end else if (state == SHIFT) begin
        data_out <= step_d;
        cnt      <= cnt - 5'd1;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit (honours SHIFT_ROTATE_EN)
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] data_in = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  shift_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: number of shift steps implied by op/shamt.
  function automatic int ref_n(input logic [2:0] o, input logic [4:0] s);
    case (o)
      3'd1, 3'd2, 3'd3: return int'(s);
      3'd4, 3'd5:       return ROT ? int'(s) : 0;
      default:          return 0;
    endcase
  endfunction

  // Reference: whole-word result computed in one go.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] d, input int n);
    logic signed [31:0] sd;
    sd = d;
    if (n == 0) return d;
    case (o)
      3'd1:    return d << n;
      3'd2:    return d >> n;
      3'd3:    return 32'(sd >>> n);
      3'd4:    return (d << n) | (d >> (32 - n));
      3'd5:    return (d >> n) | (d << (32 - n));
      default: return d;
    endcase
  endfunction

  // Launches an operation at the next edge and follows it to done.
  // glitch_edge > 0 raises start again so that edge samples it during SHIFT.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] exp, input int n,
                       input int glitch_edge);
    int done_edge;
    int busy_cnt;
    done_edge = -1;
    busy_cnt  = 0;
    op = o; data_in = d; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (done) begin
        done_edge = k;
        break;
      end
      if (busy) busy_cnt++;
      if (k + 1 == glitch_edge) begin
        start = 1'b1; op = 3'd2; data_in = $urandom; shamt = 5'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check({name, " done_edge"}, done_edge, n);
    check({name, " busy_cycles"}, busy_cnt, n);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, " data_out"}, data_out, exp);
  endtask

  task automatic idle_check(input string name, input logic [31:0] exp);
    @(posedge clk); #1;
    check({name, " done_drop"}, {30'd0, busy, done}, 32'd0);
    check({name, " hold"}, data_out, exp);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rd;
    logic [4:0]  rs;
    int          rn;
    logic [31:0] rexp;

    vecs[0] = '{3'd3, 32'h8000_0000, 5'd4,  32'hF800_0000, 4};
    vecs[1] = '{3'd0, 32'h1234_5678, 5'd7,  32'h1234_5678, 0};
    vecs[2] = '{3'd7, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 0};
    vecs[3] = '{3'd2, 32'h8000_0000, 5'd31, 32'h0000_0001, 31};
    vecs[4] = '{3'd3, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 31};
    vecs[5] = '{3'd1, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1};
    vecs[6] = ROT ? '{3'd5, 32'h0000_0001, 5'd1, 32'h8000_0000, 1}
                  : '{3'd5, 32'h0000_0001, 5'd1, 32'h0000_0001, 0};
    vecs[7] = ROT ? '{3'd4, 32'h8000_0001, 5'd4, 32'h0000_0018, 4}
                  : '{3'd4, 32'h8000_0001, 5'd4, 32'h8000_0001, 0};

    #1;
    check("reset data_out", data_out, 32'd0);
    check("reset busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset idle", {30'd0, busy, done}, 32'd0);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].sh,
            vecs[i].exp, vecs[i].n, 0);
      idle_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    do_op("sll31_glitch", 3'd1, 32'h0000_0001, 5'd31, 32'h8000_0000, 31, 10);
    idle_check("sll31_glitch", 32'h8000_0000);

    do_op("srl0", 3'd2, 32'hF000_0000, 5'd0, 32'hF000_0000, 0, 0);
    do_op("srl8_b2b", 3'd2, 32'hF000_0000, 5'd8, 32'h00F0_0000, 8, 0);
    idle_check("srl8_b2b", 32'h00F0_0000);

    op = 3'd1; data_in = 32'h0000_FFFF; shamt = 5'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("midop busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midop reset busy_done", {30'd0, busy, done}, 32'd0);
    check("midop reset data_out", data_out, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midop released idle", {30'd0, busy, done}, 32'd0);
    check("midop released data", data_out, 32'd0);
    do_op("after_reset", 3'd1, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 16, 0);
    idle_check("after_reset", 32'hFFFF_0000);

    for (int i = 0; i < 150; i++) begin
      ro   = 3'($urandom_range(0, 7));
      rd   = $urandom;
      rs   = 5'($urandom_range(0, 31));
      rn   = ref_n(ro, rs);
      rexp = ref_res(ro, rd, rn);
      do_op($sformatf("rand%0d op%0d sh%0d", i, ro, rs), ro, rd, rs, rexp, rn, 0);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i), rexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
